mpu_store: RTL and testbench

- Counterpart of the matrix load path: register file → external sink.
- On request, reads one matrix register element by element in row-major order and streams each floating-point element out with a valid/ready handshake.
- Sits between the MPU register file read port and the memory/file interface.
- Reports the stored matrix dimensions and flags dimension errors.

---
 rtl/mpu_store_pkg.sv | 31 +++
 rtl/mpu_store_fifo.sv | 67 ++++++
 rtl/mpu_store.sv | 162 ++++++++++++++++
 tb/tb_mpu_store.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_store_pkg.sv
// Shared widths, matrix limits and types for the MPU store path.
// Both the top and its output buffer import this package.
package mpu_store_pkg;

  localparam int unsigned FPBITS           = 31;
  localparam int unsigned MBITS            = 3;
  localparam int unsigned NBITS            = 3;
  localparam int unsigned MATRIX_REG_BITS  = 2;
  localparam int unsigned M                = 4;
  localparam int unsigned N                = 4;
  localparam int unsigned STORE_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    STORE_IDLE,
    STORE_SIZE,
    STORE_MATRIX,
    STORE_DONE
  } store_state_t;

  typedef struct packed {
    logic [MATRIX_REG_BITS:0] addr;
    logic [MBITS:0]           i;
    logic [NBITS:0]           j;
  } reg_req_t;

  // A stored matrix is streamable only if both dimensions are within 1..limit.
  function automatic logic dims_bad(input logic [MBITS:0] m, input logic [NBITS:0] n);
    return (m == '0) || (n == '0) || (m > (MBITS+1)'(M)) || (n > (NBITS+1)'(N));
  endfunction

endpackage

// File: rtl/mpu_store_fifo.sv
// Small synchronous FIFO holding register-file read data until the sink takes it.
// The head is always presented; valid is a registered "not empty" flag.
module mpu_store_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [WIDTH-1:0]             head_o,
  output logic                         valid_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             valid_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Simultaneous push and pop leave the occupancy unchanged.
  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_i && pop_i) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = valid_q;

endmodule

// File: rtl/mpu_store.sv
// Streams one matrix register out of the MPU register file, row-major,
// over a valid/ready interface, after probing and validating its dimensions.
module mpu_store
  import mpu_store_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = STORE_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     store_en_in,
  input  logic [MATRIX_REG_BITS:0] mem_store_addr_in,
  input  logic                     mem_store_ready_in,
  output logic                     mem_store_valid_out,
  output logic [FPBITS:0]          mem_store_element_out,
  output logic [MBITS:0]           mem_m_store_size_out,
  output logic [NBITS:0]           mem_n_store_size_out,
  output logic                     mem_store_ack_out,
  output logic                     mem_store_done_out,
  output logic                     mem_store_error_out,
  output logic                     reg_store_en_out,
  output logic [MATRIX_REG_BITS:0] reg_store_addr_out,
  output logic [MBITS:0]           reg_i_store_loc_out,
  output logic [NBITS:0]           reg_j_store_loc_out,
  input  logic [FPBITS:0]          reg_store_element_in,
  input  logic [MBITS:0]           reg_m_store_size_in,
  input  logic [NBITS:0]           reg_n_store_size_in
);

  localparam int unsigned TOT_W = MBITS + NBITS + 2;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  store_state_t     state_q;
  reg_req_t         req_q;
  logic             req_en_q;
  logic             elem_rd_q;
  logic             ack_q;
  logic             done_q;
  logic             err_q;
  logic [MBITS:0]   m_q;
  logic [NBITS:0]   n_q;
  logic [MBITS:0]   row_q;
  logic [NBITS:0]   col_q;
  logic [TOT_W-1:0] total_q;
  logic [TOT_W-1:0] xfer_q;

  logic [CNT_W-1:0] fifo_count;
  logic             pop;
  logic             issue;

  // A pop on this edge frees a slot, so the read issued alongside it still fits.
  always_comb begin
    pop   = mem_store_valid_out && mem_store_ready_in;
    issue = 1'b0;
    if ((state_q == STORE_MATRIX) && (row_q < m_q)) begin
      issue = (32'(fifo_count) + 32'(elem_rd_q) - 32'(pop)) < FIFO_DEPTH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= STORE_IDLE;
      req_q     <= '0;
      req_en_q  <= 1'b0;
      elem_rd_q <= 1'b0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      m_q       <= '0;
      n_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      total_q   <= '0;
      xfer_q    <= '0;
    end else begin
      req_en_q  <= 1'b0;
      elem_rd_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        STORE_IDLE: begin
          if (store_en_in) begin
            req_q.addr <= mem_store_addr_in;
            req_q.i    <= '0;
            req_q.j    <= '0;
            req_en_q   <= 1'b1;
            ack_q      <= 1'b1;
            err_q      <= 1'b0;
            state_q    <= STORE_SIZE;
          end
        end
        STORE_SIZE: begin
          m_q     <= reg_m_store_size_in;
          n_q     <= reg_n_store_size_in;
          total_q <= TOT_W'(reg_m_store_size_in) * TOT_W'(reg_n_store_size_in);
          row_q   <= '0;
          col_q   <= '0;
          xfer_q  <= '0;
          if (dims_bad(reg_m_store_size_in, reg_n_store_size_in)) begin
            err_q   <= 1'b1;
            ack_q   <= 1'b0;
            state_q <= STORE_IDLE;
          end else begin
            state_q <= STORE_MATRIX;
          end
        end
        STORE_MATRIX: begin
          if (issue) begin
            req_en_q  <= 1'b1;
            elem_rd_q <= 1'b1;
            req_q.i   <= row_q;
            req_q.j   <= col_q;
            if (col_q == n_q - (NBITS+1)'(1)) begin
              col_q <= '0;
              row_q <= row_q + (MBITS+1)'(1);
            end else begin
              col_q <= col_q + (NBITS+1)'(1);
            end
          end
          if (pop) begin
            xfer_q <= xfer_q + TOT_W'(1);
            if (xfer_q + TOT_W'(1) == total_q) begin
              ack_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= STORE_DONE;
            end
          end
        end
        STORE_DONE: begin
          state_q <= STORE_IDLE;
        end
        default: begin
          state_q <= STORE_IDLE;
        end
      endcase
    end
  end

  // Read data arrives in the cycle its request is presented and is buffered on that edge.
  mpu_store_fifo #(
    .WIDTH (FPBITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (elem_rd_q),
    .data_i  (reg_store_element_in),
    .pop_i   (pop),
    .count_o (fifo_count),
    .head_o  (mem_store_element_out),
    .valid_o (mem_store_valid_out)
  );

  assign mem_m_store_size_out = m_q;
  assign mem_n_store_size_out = n_q;
  assign mem_store_ack_out    = ack_q;
  assign mem_store_done_out   = done_q;
  assign mem_store_error_out  = err_q;
  assign reg_store_en_out     = req_en_q;
  assign reg_store_addr_out   = req_q.addr;
  assign reg_i_store_loc_out  = req_q.i;
  assign reg_j_store_loc_out  = req_q.j;

endmodule

// File: tb/tb_mpu_store.sv
// Bench for mpu_store: a register-file model feeds the DUT, and every streamed
// element is compared against a row-major queue built from that model's contents.
module tb_mpu_store;
  import mpu_store_pkg::*;

  localparam int unsigned AW    = MATRIX_REG_BITS + 1;
  localparam int unsigned EW    = FPBITS + 1;
  localparam int unsigned MW    = MBITS + 1;
  localparam int unsigned NW    = NBITS + 1;
  localparam int unsigned DEPTH = STORE_FIFO_DEPTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          store_en_in;
  logic [AW-1:0] mem_store_addr_in;
  logic          mem_store_ready_in;
  logic          mem_store_valid_out;
  logic [EW-1:0] mem_store_element_out;
  logic [MW-1:0] mem_m_store_size_out;
  logic [NW-1:0] mem_n_store_size_out;
  logic          mem_store_ack_out;
  logic          mem_store_done_out;
  logic          mem_store_error_out;
  logic          reg_store_en_out;
  logic [AW-1:0] reg_store_addr_out;
  logic [MW-1:0] reg_i_store_loc_out;
  logic [NW-1:0] reg_j_store_loc_out;
  logic [EW-1:0] reg_store_element_in;
  logic [MW-1:0] reg_m_store_size_in;
  logic [NW-1:0] reg_n_store_size_in;

  always #5 clk = ~clk;

  mpu_store dut (
    .clk                   (clk),
    .rst                   (rst),
    .store_en_in           (store_en_in),
    .mem_store_addr_in     (mem_store_addr_in),
    .mem_store_ready_in    (mem_store_ready_in),
    .mem_store_valid_out   (mem_store_valid_out),
    .mem_store_element_out (mem_store_element_out),
    .mem_m_store_size_out  (mem_m_store_size_out),
    .mem_n_store_size_out  (mem_n_store_size_out),
    .mem_store_ack_out     (mem_store_ack_out),
    .mem_store_done_out    (mem_store_done_out),
    .mem_store_error_out   (mem_store_error_out),
    .reg_store_en_out      (reg_store_en_out),
    .reg_store_addr_out    (reg_store_addr_out),
    .reg_i_store_loc_out   (reg_i_store_loc_out),
    .reg_j_store_loc_out   (reg_j_store_loc_out),
    .reg_store_element_in  (reg_store_element_in),
    .reg_m_store_size_in   (reg_m_store_size_in),
    .reg_n_store_size_in   (reg_n_store_size_in)
  );

  // Register-file model: answers the presented request during the same cycle.
  logic [EW-1:0] mat [0:7][0:15][0:15];
  int unsigned   msz [0:7];
  int unsigned   nsz [0:7];

  assign reg_store_element_in = mat[reg_store_addr_out][reg_i_store_loc_out][reg_j_store_loc_out];
  assign reg_m_store_size_in  = MW'(msz[reg_store_addr_out]);
  assign reg_n_store_size_in  = NW'(nsz[reg_store_addr_out]);

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int addr;
    int stall_after;
    int stall_len;
    bit rnd;
    bit pulse;
    bit exp_err;
    int exp_cnt;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " valid"},   64'(mem_store_valid_out),   64'(0));
    check({tag, " element"}, 64'(mem_store_element_out), 64'(0));
    check({tag, " m_size"},  64'(mem_m_store_size_out),  64'(0));
    check({tag, " n_size"},  64'(mem_n_store_size_out),  64'(0));
    check({tag, " ack"},     64'(mem_store_ack_out),     64'(0));
    check({tag, " done"},    64'(mem_store_done_out),    64'(0));
    check({tag, " error"},   64'(mem_store_error_out),   64'(0));
    check({tag, " reg_en"},  64'(reg_store_en_out),      64'(0));
    check({tag, " reg_addr"},64'(reg_store_addr_out),    64'(0));
    check({tag, " reg_i"},   64'(reg_i_store_loc_out),   64'(0));
    check({tag, " reg_j"},   64'(reg_j_store_loc_out),   64'(0));
  endtask

  task automatic fill(input int a, input int m, input int n);
    msz[a] = m;
    nsz[a] = n;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        mat[a][i][j] = EW'($urandom);
  endtask

  // One complete store: start, size probe, streaming with the chosen ready pattern.
  task automatic do_store(input int a, input int stall_after, input int stall_len, input bit rnd,
                          input bit pulse, input bit exp_err, input int exp_cnt, input string tag);
    logic [EW-1:0] exp_q [$];
    logic [EW-1:0] held_val;
    logic [EW-1:0] want;
    logic          rdy;
    bit            held, seen_done, completed, model_bad;
    int            m, n, xfers, reads, dones, first_x, last_x, done_at, holds, max_out, stall_left;
    m = int'(msz[a]);
    n = int'(nsz[a]);
    model_bad = (m == 0) || (n == 0) || (m > int'(M)) || (n > int'(N));
    if (!model_bad)
      for (int i = 0; i < m; i++)
        for (int j = 0; j < n; j++)
          exp_q.push_back(mat[a][i][j]);
    xfers = 0; reads = 0; dones = 0; first_x = -1; last_x = -1; done_at = -1;
    holds = 0; max_out = 0; stall_left = 0; held = 1'b0; seen_done = 1'b0; completed = 1'b0;
    held_val = '0;

    @(negedge clk);
    store_en_in       = 1'b1;
    mem_store_addr_in = AW'(a);
    @(negedge clk);
    store_en_in = 1'b0;
    check({tag, " start ack"},    64'(mem_store_ack_out),   64'(1));
    check({tag, " start err"},    64'(mem_store_error_out), 64'(0));
    check({tag, " probe en"},     64'(reg_store_en_out),    64'(1));
    check({tag, " probe addr"},   64'(reg_store_addr_out),  64'(a));
    @(negedge clk);
    check({tag, " size err"},     64'(mem_store_error_out), 64'(exp_err));
    check({tag, " size ack"},     64'(mem_store_ack_out),   64'(!exp_err));
    check({tag, " m_size"},       64'(mem_m_store_size_out), 64'(m));
    check({tag, " n_size"},       64'(mem_n_store_size_out), 64'(n));

    for (int cyc = 0; cyc < 300; cyc++) begin
      if (held && !(mem_store_valid_out && (mem_store_element_out == held_val))) holds++;
      if (reg_store_en_out) reads++;
      if (reads - xfers > max_out) max_out = reads - xfers;
      if (mem_store_done_out) begin
        dones++;
        if (!seen_done) begin
          seen_done = 1'b1;
          done_at   = cyc;
          check({tag, " ack at done"}, 64'(mem_store_ack_out), 64'(0));
          check({tag, " done after last xfer"}, 64'(done_at), 64'(last_x + 1));
        end
      end
      if (seen_done && cyc == done_at + 2) begin completed = 1'b1; break; end
      if (exp_err && cyc == 4) begin completed = 1'b1; break; end

      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else if (rnd) begin
        rdy = ($urandom_range(3) != 0);
      end else begin
        rdy = 1'b1;
      end
      mem_store_ready_in = rdy;
      if (pulse && cyc == 2) begin
        store_en_in       = 1'b1;
        mem_store_addr_in = AW'(4);
      end else begin
        store_en_in = 1'b0;
      end
      held     = mem_store_valid_out && !rdy;
      held_val = mem_store_element_out;
      if (mem_store_valid_out && rdy) begin
        if (exp_q.size() == 0) begin
          check({tag, " extra xfer"}, 64'(mem_store_element_out), 64'(0) - 64'(1));
        end else begin
          want = exp_q.pop_front();
          check($sformatf("%s elem%0d", tag, xfers), 64'(mem_store_element_out), 64'(want));
        end
        if (xfers == 0) first_x = cyc;
        last_x = cyc;
        xfers++;
        if (xfers == stall_after) stall_left = stall_len;
      end
      @(negedge clk);
    end
    store_en_in = 1'b0;

    check({tag, " completed in budget"}, 64'(completed), 64'(1));
    check({tag, " xfers"},     64'(xfers), 64'(exp_cnt));
    check({tag, " reads"},     64'(reads), 64'(exp_cnt));
    check({tag, " done count"}, 64'(dones), 64'(exp_err ? 0 : 1));
    check({tag, " leftover"},  64'(exp_q.size()), 64'(0));
    check({tag, " held stable"}, 64'(holds), 64'(0));
    check({tag, " max outstanding"}, 64'(max_out),
          64'((exp_cnt < int'(DEPTH)) ? exp_cnt : int'(DEPTH)));
    check({tag, " end ack"},   64'(mem_store_ack_out),   64'(0));
    check({tag, " end valid"}, 64'(mem_store_valid_out), 64'(0));
    check({tag, " end err"},   64'(mem_store_error_out), 64'(exp_err));
    if (!exp_err && !rnd && stall_len == 0)
      check({tag, " back-to-back"}, 64'(last_x - first_x), 64'(exp_cnt - 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, d, v, m, n;
    bit bad;
    for (int a = 0; a < 8; a++) fill(a, 0, 0);
    fill(1, 2, 3);
    mat[1][0][0] = 32'h3F80_0000; mat[1][0][1] = 32'h4000_0000; mat[1][0][2] = 32'h4040_0000;
    mat[1][1][0] = 32'h4080_0000; mat[1][1][1] = 32'h40A0_0000; mat[1][1][2] = 32'h40C0_0000;
    fill(2, 0, 3);
    fill(3, int'(M) + 1, 2);
    fill(4, 1, 1);
    mat[4][0][0] = 32'h40F0_0000;
    fill(7, 2, int'(N) + 1);
    fill(0, 4, 1);

    //           addr stall_after stall_len rnd pulse err cnt
    vecs[0] = '{1, 0, 0, 1'b0, 1'b0, 1'b0, 6};
    vecs[1] = '{1, 2, 3, 1'b0, 1'b0, 1'b0, 6};
    vecs[2] = '{2, 0, 0, 1'b0, 1'b0, 1'b1, 0};
    vecs[3] = '{4, 0, 0, 1'b0, 1'b0, 1'b0, 1};
    vecs[4] = '{3, 0, 0, 1'b0, 1'b0, 1'b1, 0};
    vecs[5] = '{7, 0, 0, 1'b0, 1'b0, 1'b1, 0};
    vecs[6] = '{1, 0, 0, 1'b0, 1'b1, 1'b0, 6};
    vecs[7] = '{0, 0, 0, 1'b1, 1'b0, 1'b0, 4};

    rst = 1'b1; store_en_in = 1'b0; mem_store_addr_in = '0; mem_store_ready_in = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    for (int k = 0; k < 8; k++)
      do_store(vecs[k].addr, vecs[k].stall_after, vecs[k].stall_len, vecs[k].rnd,
               vecs[k].pulse, vecs[k].exp_err, vecs[k].exp_cnt, $sformatf("vec%0d", k));

    // Randomized dimensions, contents and ready pattern against the queue model.
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(3) == 0) begin
        m = int'($urandom_range(5));
        n = int'($urandom_range(5));
      end else begin
        m = int'($urandom_range(4, 1));
        n = int'($urandom_range(4, 1));
      end
      fill(6, m, n);
      bad = (m == 0) || (n == 0) || (m > int'(M)) || (n > int'(N));
      do_store(6, int'($urandom_range(3)), int'($urandom_range(4)), 1'(($urandom_range(1))), 1'b0,
               bad, bad ? 0 : m * n, $sformatf("rnd%0d_%0dx%0d", r, m, n));
    end

    // Reset in the middle of a full-size store.
    fill(5, int'(M), int'(N));
    @(negedge clk);
    store_en_in = 1'b1; mem_store_addr_in = AW'(5); mem_store_ready_in = 1'b1;
    @(negedge clk);
    store_en_in = 1'b0;
    x = 0;
    for (int c = 0; c < 40 && x < 3; c++) begin
      if (mem_store_valid_out) x++;
      @(negedge clk);
    end
    check("rst_mid xfers before reset", 64'(x), 64'(3));
    rst = 1'b1;
    @(negedge clk);
    check_zero("rst_mid");
    rst = 1'b0;
    d = 0; v = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_store_done_out) d++;
      if (mem_store_valid_out) v++;
    end
    check("rst_mid no done", 64'(d), 64'(0));
    check("rst_mid no valid", 64'(v), 64'(0));
    do_store(5, 0, 0, 1'b0, 1'b0, 1'b0, int'(M * N), "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
